// File: rtl/commit_controller.sv
// commit_controller: in-order retirement of the ROB head, one entry per cycle at most.
// Drives the RF write port, the LSB store-commit handshake and the global flush/redirect.
`default_nettype none

module commit_controller #(
    parameter int ROB_WIDTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 headValid,
    input  logic                 headReady,
    input  logic [1:0]           headType,
    input  logic [4:0]           headDest,
    input  logic [31:0]          headValue,
    input  logic [ROB_WIDTH-1:0] headRobId,
    input  logic                 headMispredict,
    input  logic [31:0]          headTarget,
    input  logic                 storeDoneIn,
    output logic                 robPopOut,
    output logic                 regUpdateValid,
    output logic [4:0]           regUpdateDest,
    output logic [31:0]          regUpdateValue,
    output logic [ROB_WIDTH-1:0] regUpdateRobId,
    output logic                 storeCommitOut,
    output logic                 clearOut,
    output logic                 redirectValid,
    output logic [31:0]          redirectPc,
    output logic                 haltOut,
    output logic [31:0]          commitCount
);

    localparam logic [1:0] c_TYPE_REG    = 2'b00;
    localparam logic [1:0] c_TYPE_STORE  = 2'b01;
    localparam logic [1:0] c_TYPE_BRANCH = 2'b10;
    localparam logic [1:0] c_TYPE_HALT   = 2'b11;

    typedef enum logic [1:0] {
        ST_ACTIVE     = 2'd0,
        ST_STORE_WAIT = 2'd1,
        ST_FLUSH      = 2'd2
    } state_t;

    state_t                 r_state, w_state;
    logic [3:0]             r_flush_cnt, w_flush_cnt;
    logic                   r_pop, w_pop;
    logic                   r_reg_valid, w_reg_valid;
    logic [4:0]             r_dest, w_dest;
    logic [31:0]            r_value, w_value;
    logic [ROB_WIDTH-1:0]   r_robid, w_robid;
    logic                   r_store, w_store;
    logic                   r_clear, w_clear;
    logic                   r_redir, w_redir;
    logic [31:0]            r_pc, w_pc;
    logic                   r_halt, w_halt;
    logic [31:0]            r_count, w_count;
    logic                   w_accept;

    assign w_accept = (r_state == ST_ACTIVE) && readyIn && headValid && headReady && !r_halt;

    always_comb begin
        w_state     = r_state;
        w_flush_cnt = r_flush_cnt;
        w_pop       = 1'b0;
        w_reg_valid = 1'b0;
        w_dest      = r_dest;
        w_value     = r_value;
        w_robid     = r_robid;
        w_store     = 1'b0;
        w_clear     = 1'b0;
        w_redir     = 1'b0;
        w_pc        = r_pc;
        w_halt      = r_halt;

        case (r_state)
            ST_ACTIVE: begin
                if (w_accept) begin
                    case (headType)
                        c_TYPE_STORE: begin
                            w_store = 1'b1;
                            w_state = ST_STORE_WAIT;
                        end
                        c_TYPE_HALT: begin
                            w_pop  = 1'b1;
                            w_halt = 1'b1;
                        end
                        default: begin
                            // REG and BRANCH both retire with an optional RF write; x0 is never written
                            w_pop = 1'b1;
                            if (headDest != 5'd0) begin
                                w_reg_valid = 1'b1;
                                w_dest      = headDest;
                                w_value     = headValue;
                                w_robid     = headRobId;
                            end
                            if (headType == c_TYPE_BRANCH && headMispredict) begin
                                w_clear     = 1'b1;
                                w_redir     = 1'b1;
                                w_pc        = headTarget;
                                w_state     = ST_FLUSH;
                                w_flush_cnt = 4'(FLUSH_CYCLES);
                            end
                        end
                    endcase
                end
            end
            ST_STORE_WAIT: begin
                if (storeDoneIn) begin
                    w_pop   = 1'b1;
                    w_state = ST_ACTIVE;
                end
            end
            ST_FLUSH: begin
                w_flush_cnt = r_flush_cnt - 4'd1;
                if (r_flush_cnt <= 4'd1) begin
                    w_flush_cnt = 4'd0;
                    w_state     = ST_ACTIVE;
                end
            end
            default: begin
                w_state     = ST_ACTIVE;
                w_flush_cnt = 4'd0;
            end
        endcase
    end

    assign w_count = r_count + {31'd0, w_pop};

    always_ff @(posedge clockIn) begin
        if (resetIn) begin
            r_state     <= ST_ACTIVE;
            r_flush_cnt <= 4'd0;
            r_pop       <= 1'b0;
            r_reg_valid <= 1'b0;
            r_dest      <= 5'd0;
            r_value     <= 32'd0;
            r_robid     <= '0;
            r_store     <= 1'b0;
            r_clear     <= 1'b0;
            r_redir     <= 1'b0;
            r_pc        <= 32'd0;
            r_halt      <= 1'b0;
            r_count     <= 32'd0;
        end else begin
            r_state     <= w_state;
            r_flush_cnt <= w_flush_cnt;
            r_pop       <= w_pop;
            r_reg_valid <= w_reg_valid;
            r_dest      <= w_dest;
            r_value     <= w_value;
            r_robid     <= w_robid;
            r_store     <= w_store;
            r_clear     <= w_clear;
            r_redir     <= w_redir;
            r_pc        <= w_pc;
            r_halt      <= w_halt;
            r_count     <= w_count;
        end
    end

    assign robPopOut      = r_pop;
    assign regUpdateValid = r_reg_valid;
    assign regUpdateDest  = r_dest;
    assign regUpdateValue = r_value;
    assign regUpdateRobId = r_robid;
    assign storeCommitOut = r_store;
    assign clearOut       = r_clear;
    assign redirectValid  = r_redir;
    assign redirectPc     = r_pc;
    assign haltOut        = r_halt;
    assign commitCount    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_commit_controller.sv
// tb_commit_controller: scoreboard bench; a transaction-level model predicts each commit event.
`default_nettype none

module tb_commit_controller;

    localparam int ROB_WIDTH    = 4;
    localparam int FLUSH_CYCLES = 2;

    logic                 clockIn = 1'b0;
    logic                 resetIn, readyIn, headValid, headReady, headMispredict, storeDoneIn;
    logic [1:0]           headType;
    logic [4:0]           headDest;
    logic [31:0]          headValue, headTarget;
    logic [ROB_WIDTH-1:0] headRobId;
    logic                 robPopOut, regUpdateValid, storeCommitOut, clearOut, redirectValid, haltOut;
    logic [4:0]           regUpdateDest;
    logic [31:0]          regUpdateValue, redirectPc, commitCount;
    logic [ROB_WIDTH-1:0] regUpdateRobId;

    always #5 clockIn = ~clockIn;

    commit_controller #(.ROB_WIDTH(ROB_WIDTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn), .headValid(headValid),
        .headReady(headReady), .headType(headType), .headDest(headDest), .headValue(headValue),
        .headRobId(headRobId), .headMispredict(headMispredict), .headTarget(headTarget),
        .storeDoneIn(storeDoneIn), .robPopOut(robPopOut), .regUpdateValid(regUpdateValid),
        .regUpdateDest(regUpdateDest), .regUpdateValue(regUpdateValue),
        .regUpdateRobId(regUpdateRobId), .storeCommitOut(storeCommitOut), .clearOut(clearOut),
        .redirectValid(redirectValid), .redirectPc(redirectPc), .haltOut(haltOut),
        .commitCount(commitCount)
    );

    typedef struct {
        int unsigned          cyc;
        logic                 pop, regv, store, clear;
        logic [4:0]           dest;
        logic [31:0]          value, pc;
        logic [ROB_WIDTH-1:0] robid;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    // Reference state: what retirement rules say has happened so far
    logic                 m_store_pending, m_halt;
    int unsigned          m_blocked_until;
    logic [4:0]           m_dest;
    logic [31:0]          m_value, m_pc, m_count;
    logic [ROB_WIDTH-1:0] m_robid;

    always @(posedge clockIn) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int unsigned c, input logic pop, input logic regv,
                            input logic store, input logic clear);
        exp_t e;
        if (pop) m_count = m_count + 32'd1;
        e.cyc = c; e.pop = pop; e.regv = regv; e.store = store; e.clear = clear;
        e.dest = m_dest; e.value = m_value; e.pc = m_pc; e.robid = m_robid;
        q.push_back(e);
    endtask

    // Decides what the coming clock edge must produce from the inputs now applied
    task automatic model_step();
        int unsigned edge_c;
        edge_c = cyc + 1;
        if (resetIn) begin
            m_store_pending = 0; m_halt = 0; m_blocked_until = 0;
            m_dest = 0; m_value = 0; m_pc = 0; m_count = 0; m_robid = 0;
        end else if (m_store_pending) begin
            if (storeDoneIn) begin
                m_store_pending = 0;
                push_exp(edge_c, 1, 0, 0, 0);
            end
        end else if (edge_c >= m_blocked_until && readyIn && headValid && headReady && !m_halt) begin
            if (headType == 2'b01) begin
                m_store_pending = 1;
                push_exp(edge_c, 0, 0, 1, 0);
            end else if (headType == 2'b11) begin
                m_halt = 1;
                push_exp(edge_c, 1, 0, 0, 0);
            end else begin
                logic mis;
                mis = (headType == 2'b10) && headMispredict;
                if (headDest != 0) begin
                    m_dest = headDest; m_value = headValue; m_robid = headRobId;
                end
                if (mis) begin
                    m_pc = headTarget;
                    m_blocked_until = edge_c + FLUSH_CYCLES + 1;
                end
                push_exp(edge_c, 1, headDest != 0, 0, mis);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(negedge clockIn);
    endtask

    task automatic set_head(input logic [1:0] t, input logic [4:0] d, input logic [31:0] v,
                            input logic [ROB_WIDTH-1:0] id, input logic mis, input logic [31:0] tgt);
        headValid = 1; headReady = 1; headType = t; headDest = d; headValue = v;
        headRobId = id; headMispredict = mis; headTarget = tgt;
    endtask

    // Monitor: any commit pulse must match the oldest predicted event, cycle included
    always begin
        @(posedge clockIn);
        #1;
        if (robPopOut || regUpdateValid || storeCommitOut || clearOut || redirectValid) begin
            if (q.size() == 0) begin
                chk("unexpected_pulse", {27'd0, robPopOut, regUpdateValid, storeCommitOut,
                                         clearOut, redirectValid}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("event_cycle", cyc, e.cyc);
                chk("robPopOut", {31'd0, robPopOut}, {31'd0, e.pop});
                chk("regUpdateValid", {31'd0, regUpdateValid}, {31'd0, e.regv});
                chk("storeCommitOut", {31'd0, storeCommitOut}, {31'd0, e.store});
                chk("clearOut", {31'd0, clearOut}, {31'd0, e.clear});
                chk("redirectValid", {31'd0, redirectValid}, {31'd0, e.clear});
                chk("regUpdateDest", {27'd0, regUpdateDest}, {27'd0, e.dest});
                chk("regUpdateValue", regUpdateValue, e.value);
                chk("regUpdateRobId", {28'd0, regUpdateRobId}, {28'd0, e.robid});
                chk("redirectPc", redirectPc, e.pc);
            end
        end
        chk("haltOut", {31'd0, haltOut}, {31'd0, m_halt});
        chk("commitCount", commitCount, m_count);
    end

    initial begin
        resetIn = 1; readyIn = 1; headValid = 0; headReady = 0; headType = 0; headDest = 0;
        headValue = 0; headRobId = 0; headMispredict = 0; headTarget = 0; storeDoneIn = 0;
        @(negedge clockIn);
        repeat (3) tick();
        resetIn = 0;
        chk("reset_pop", {31'd0, robPopOut}, 32'd0);
        chk("reset_regv", {31'd0, regUpdateValid}, 32'd0);
        chk("reset_dest", {27'd0, regUpdateDest}, 32'd0);
        chk("reset_value", regUpdateValue, 32'd0);
        chk("reset_store", {31'd0, storeCommitOut}, 32'd0);
        chk("reset_clear", {30'd0, clearOut, redirectValid}, 32'd0);
        chk("reset_pc", redirectPc, 32'd0);
        chk("reset_halt", {31'd0, haltOut}, 32'd0);
        chk("reset_count", commitCount, 32'd0);

        // Plain REG commit, then x0 destination, then readyIn held low
        set_head(2'b00, 5'd5, 32'h1234, 4'd3, 0, 0); tick();
        headValid = 0; tick();
        chk("first_commit_count", commitCount, 32'd1);
        set_head(2'b00, 5'd0, 32'hDEAD, 4'd4, 0, 0); tick();
        readyIn = 0; set_head(2'b00, 5'd6, 32'h55, 4'd5, 0, 0);
        repeat (5) tick();
        readyIn = 1; headValid = 0; tick();

        // STORE: head changes while waiting for the LSB are ignored
        set_head(2'b01, 5'd0, 32'h0, 4'd6, 0, 0); tick();
        set_head(2'b00, 5'd7, 32'h77, 4'd7, 0, 0);
        repeat (2) tick();
        storeDoneIn = 1; tick();
        storeDoneIn = 0; headValid = 0; tick();

        // Mispredicted branch, then a ready head held through the flush window
        set_head(2'b10, 5'd1, 32'h40, 4'd8, 1, 32'h100); tick();
        set_head(2'b00, 5'd2, 32'h22, 4'd9, 0, 0);
        repeat (4) tick();
        headValid = 0; tick();

        // HALT is sticky until reset
        set_head(2'b11, 5'd0, 32'h0, 4'd10, 0, 0); tick();
        set_head(2'b00, 5'd3, 32'h33, 4'd11, 0, 0);
        repeat (3) tick();
        resetIn = 1; tick();
        resetIn = 0; tick();

        // Reset while in STORE_WAIT, then while in FLUSH
        set_head(2'b01, 5'd0, 32'h0, 4'd1, 0, 0); tick();
        headValid = 0; tick();
        resetIn = 1; tick();
        resetIn = 0; storeDoneIn = 1; tick();
        storeDoneIn = 0;
        set_head(2'b10, 5'd4, 32'h44, 4'd2, 1, 32'h200); tick();
        headValid = 0; resetIn = 1; tick();
        resetIn = 0; set_head(2'b00, 5'd9, 32'h99, 4'd3, 0, 0); tick();
        headValid = 0; tick();

        // Counter wrap from a preset value
        force dut.r_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_count;
        m_count = 32'hFFFF_FFFE;
        set_head(2'b00, 5'd3, 32'hABCD, 4'd5, 0, 0);
        repeat (2) tick();
        headValid = 0; tick();
        chk("count_wrap", commitCount, 32'd0);

        for (int i = 0; i < 2500; i++) begin
            int unsigned r;
            resetIn        = ($urandom % 60) == 0;
            readyIn        = ($urandom % 10) != 0;
            headValid      = ($urandom % 4) != 0;
            headReady      = ($urandom % 3) != 0;
            r              = $urandom % 20;
            headType       = (r < 9) ? 2'b00 : (r < 14) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
            headDest       = 5'($urandom % 8);
            headValue      = $urandom;
            headRobId      = ROB_WIDTH'($urandom);
            headMispredict = ($urandom % 2) == 0;
            headTarget     = $urandom;
            storeDoneIn    = ($urandom % 3) == 0;
            tick();
        end

        resetIn = 0; headValid = 0; storeDoneIn = 0;
        repeat (6) tick();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
